// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external async 16-bit SRAM between client 0 (display/readback)
// and client 1 (capture/writer), one single-word access every 2 cycles.
// Ports:
//   i_clk, i_rst_n (sync, active low), i_clear (sync abort back to IDLE)
//   i_req[1:0], i_we[1:0], i_addr0/1, i_wdata0/1 : per-client request, held until o_gnt
//   o_gnt[1:0]    : one-hot 1-cycle grant pulse
//   o_rvalid[1:0] : one-hot 1-cycle read-data-valid pulse, o_rdata holds the last read word
//   o_busy        : high while an access is on the pins
//   o_SRAM_*      : chip pins; io_SRAM_DQ driven only while o_SRAM_WE_N is low
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed client-0 priority on ties with a
// starvation counter for client 1 (MAX_WAIT); otherwise ties are round-robin.
module sram_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);
    typedef enum logic {IDLE, ACCESS} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              we_n_q, we_n_d, owner_q, owner_d;
    logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic              grant, win, rd_done;
    // a grant is only issued from IDLE, and an abort suppresses it
    assign grant   = (state_q == IDLE) && (i_req != 2'b00) && !i_clear;
    assign rd_done = (state_q == ACCESS) && we_n_q && !i_clear;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    logic [WC_W-1:0] wait_cnt_q;
    // client 0 wins ties unless client 1 has already lost MAX_WAIT times
    assign win = (i_req == 2'b11) ? (wait_cnt_q == WC_W'(MAX_WAIT)) : i_req[1];
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) wait_cnt_q <= '0;
        else if (grant && i_req[1]) wait_cnt_q <= win ? '0 : wait_cnt_q + 1'b1;
    end
`else
    localparam int unused_max_wait = MAX_WAIT;
    logic last_q;
    // ties go to whoever was not served last; reset value 1 lets client 0 win first
    assign win = (i_req == 2'b11) ? ~last_q : i_req[1];
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) last_q <= 1'b1;
        else if (grant) last_q <= win;
    end
`endif
    always_comb begin
        state_d  = grant ? ACCESS : IDLE;
        addr_d   = grant ? (win ? i_addr1 : i_addr0) : addr_q;
        wdata_d  = grant ? (win ? i_wdata1 : i_wdata0) : wdata_q;
        we_n_d   = grant ? ~i_we[win] : 1'b1;
        gnt_d    = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
        owner_d  = grant ? win : owner_q;
        rvalid_d = rd_done ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        rdata_d  = rd_done ? io_SRAM_DQ : rdata_q;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_n_q   <= 1'b1;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_n_q   <= we_n_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end
    assign io_SRAM_DQ  = we_n_q ? 'z : wdata_q;
    assign o_gnt       = gnt_q;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_busy      = (state_q == ACCESS);
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_WE_N = we_n_q;
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_OE_N = 1'b0;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
endmodule
